// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: handles memory-wait stalls, redirect flushes, load-use bubbles and a sticky wait timeout.
// Define HAZARD_PERF_CNT_EN to add the stall/flush performance counters.
module pipeline_hazard_unit #(
  parameter int NBits    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1_i,
  input  logic [4:0]       IF_ID_rs2_i,
  input  logic             IF_ID_use_rs1_i,
  input  logic             IF_ID_use_rs2_i,
  input  logic             ID_EX_mem_read_i,
  input  logic [4:0]       ID_EX_write_register_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_jalr_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_write_o,
  output logic             ID_EX_bubble_o,
  output logic             wait_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [NBits-1:0] stall_cnt_o,
  output logic [NBits-1:0] flush_cnt_o
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic            lu, redir;

  always_comb begin
    lu = ID_EX_mem_read_i && (ID_EX_write_register_i != 5'd0) &&
         (((ID_EX_write_register_i == IF_ID_rs1_i) && IF_ID_use_rs1_i) ||
          ((ID_EX_write_register_i == IF_ID_rs2_i) && IF_ID_use_rs2_i));
    redir = ex_branch_taken_i | ex_jalr_i;

    pc_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_write_o  = 1'b1;
    ID_EX_bubble_o = 1'b0;
    state_d        = RUN;

    // MEM_WAIT with memory ready falls through to the RUN rules.
    if (dmem_busy_i) begin
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      ID_EX_write_o = 1'b0;
      state_d       = MEM_WAIT;
    end else if (redir) begin
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
    end else if (lu && (state_q != LU_BUBBLE)) begin
      pc_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
      state_d        = LU_BUBBLE;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (dmem_busy_i) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_ONE;
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wait_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [NBits-1:0] CNT_ONE = NBits'(1);

  logic [NBits-1:0] stall_cnt_q, stall_cnt_d;
  logic [NBits-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (IF_ID_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
